// File: rtl/arb_pkg.sv
// +--------------------------------------------------------------------+
// | arb_pkg: shared types and helpers for the round-robin grant arbiter |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate right by sh, wrapping bit 0 around to the top.
  function automatic logic [N_REQ-1:0] rotate_right(input logic [N_REQ-1:0] v,
                                                    input logic [IDX_W-1:0] sh);
    logic [2*N_REQ-1:0] w_dbl;
    w_dbl = {v, v} >> sh;
    return w_dbl[N_REQ-1:0];
  endfunction

endpackage : arb_pkg

`default_nettype wire

// File: rtl/rr_pick_4.sv
// +--------------------------------------------------------------------+
// | rr_pick_4: rotate, priority-encode, un-rotate for 4 requesters     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_pick;

  assign w_rot = rotate_right(req, ptr);

  // 4-input priority encoder: lowest set bit wins.
  always_comb begin
    w_pick = 2'd0;
    casez (w_rot)
      4'b???1: w_pick = 2'd0;
      4'b??10: w_pick = 2'd1;
      4'b?100: w_pick = 2'd2;
      4'b1000: w_pick = 2'd3;
      default: w_pick = 2'd0;
    endcase
  end

  // 2-bit add wraps 3->0, undoing the rotation.
  assign winner = w_pick + ptr;
  assign any    = |req;

endmodule : rr_pick_4

`default_nettype wire

// File: rtl/rr_grant_arbiter_4.sv
// +--------------------------------------------------------------------+
// | rr_grant_arbiter_4: registered 4-way round-robin arbiter with      |
// | held grant, release and hold-timeout | rev 1.0                    |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_grant_arbiter_4
  import arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic [N_REQ-1:0] grant_onehot_o,
  output logic             timeout_o
);

  generate
    if (N_REQ != 4) begin : g_bad_n_req
      $error("rr_grant_arbiter_4: N_REQ must be 4");
    end
    if (IDX_W != 2) begin : g_bad_idx_w
      $error("rr_grant_arbiter_4: IDX_W must be 2");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
      $error("rr_grant_arbiter_4: TIMEOUT out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic             w_owner_drop;
  logic             w_expired;

  rr_pick_4 u_pick (
    .req    (req_i),
    .ptr    (r_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_owner_drop = ~req_i[grant_idx_o];
  assign w_expired    = (r_hold_cnt == c_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_hold_cnt     <= '0;
      grant_valid_o  <= 1'b0;
      grant_idx_o    <= '0;
      grant_onehot_o <= '0;
      timeout_o      <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state        <= GRANT;
            grant_valid_o  <= 1'b1;
            grant_idx_o    <= w_winner;
            grant_onehot_o <= N_REQ'(1) << w_winner;
            r_hold_cnt     <= c_one;
            r_ptr          <= w_winner + 1'b1;
          end
        end
        GRANT: begin
          if (release_i || w_owner_drop || w_expired) begin
            r_state        <= IDLE;
            grant_valid_o  <= 1'b0;
            grant_idx_o    <= '0;
            grant_onehot_o <= '0;
            r_hold_cnt     <= '0;
            // A voluntary exit on the same cycle masks the timeout pulse.
            timeout_o      <= w_expired && !release_i && !w_owner_drop;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_one;
          end
        end
        default: begin
          r_state        <= IDLE;
          grant_valid_o  <= 1'b0;
          grant_idx_o    <= '0;
          grant_onehot_o <= '0;
          r_hold_cnt     <= '0;
        end
      endcase
    end
  end

endmodule : rr_grant_arbiter_4

`default_nettype wire

// File: tb/tb_rr_grant_arbiter_4.sv
// +--------------------------------------------------------------------+
// | tb_rr_grant_arbiter_4: directed bench for rr_grant_arbiter_4       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rr_grant_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic       release_i;
  logic       grant_valid_o;
  logic [1:0] grant_idx_o;
  logic [3:0] grant_onehot_o;
  logic       timeout_o;

  int checks;
  int errors;

  rr_grant_arbiter_4 #(
    .N_REQ   (4),
    .IDX_W   (2),
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .release_i      (release_i),
    .grant_valid_o  (grant_valid_o),
    .grant_idx_o    (grant_idx_o),
    .grant_onehot_o (grant_onehot_o),
    .timeout_o      (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    chk({tag, "_valid"}, 8'(grant_valid_o), 8'd1);
    chk({tag, "_idx"}, 8'(grant_idx_o), 8'(idx));
    chk({tag, "_onehot"}, 8'(grant_onehot_o), 8'(oh));
  endtask

  task automatic chk_idle(input string tag, input logic exp_to);
    chk({tag, "_valid"}, 8'(grant_valid_o), 8'd0);
    chk({tag, "_onehot"}, 8'(grant_onehot_o), 8'd0);
    chk({tag, "_timeout"}, 8'(timeout_o), 8'(exp_to));
  endtask

  // Release the current owner, then expect one IDLE cycle and a new grant.
  task automatic release_and_regrant(input string tag, input logic [1:0] idx);
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    chk_idle({tag, "_gap"}, 1'b0);
    tick();
    chk_grant(tag, idx);
  endtask

  logic [1:0] rot_seq [5];

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_i     = 4'b1111;
    release_i = 1'b0;
    rot_seq   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held for two edges with all requests asserted.
    tick();
    tick();
    chk_idle("reset", 1'b0);
    chk("reset_idx", 8'(grant_idx_o), 8'd0);

    rst = 1'b0;
    tick();
    chk_grant("first", rot_seq[0]);

    // Rotation 0,1,2,3,0 with one IDLE cycle between grants.
    for (int k = 1; k < 5; k++) begin
      release_and_regrant($sformatf("rot%0d", k), rot_seq[k]);
    end

    // ptr=1: grant 2 alone, moving ptr to 3.
    req_i = 4'b0100;
    release_and_regrant("only2", 2'd2);

    // ptr=3, requests 0 and 2: search wraps to 0, then on to 2.
    req_i = 4'b0101;
    release_and_regrant("wrap0", 2'd0);
    release_and_regrant("wrap2", 2'd2);

    // ptr=3, only requester 1: grant 1, then it drops its request.
    req_i = 4'b0010;
    release_and_regrant("own1", 2'd1);
    req_i = 4'b0000;
    tick();
    chk_idle("drop", 1'b0);

    // Timeout: 4 grant cycles, forced drop with pulse, regrant after IDLE.
    req_i = 4'b0010;
    tick();
    chk_grant("to_c1", 2'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_grant($sformatf("to_c%0d", c), 2'd1);
      chk($sformatf("to_c%0d_pulse", c), 8'(timeout_o), 8'd0);
    end
    tick();
    chk_idle("to_drop", 1'b1);
    tick();
    chk_grant("to_regrant", 2'd1);
    chk("to_pulse_end", 8'(timeout_o), 8'd0);

    // Release on the hold_cnt==TIMEOUT cycle suppresses the pulse.
    tick();
    tick();
    tick();
    chk_grant("col_c4", 2'd1);
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    chk_idle("collision", 1'b0);

    // ptr=2 with all requesting: grant 2, then reset mid-grant.
    req_i = 4'b1111;
    tick();
    chk_grant("pre_rst", 2'd2);
    rst = 1'b1;
    tick();
    chk_idle("mid_rst", 1'b0);
    chk("mid_rst_idx", 8'(grant_idx_o), 8'd0);
    rst = 1'b0;
    tick();
    chk_grant("post_rst", 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_grant_arbiter_4

`default_nettype wire
